// File: rtl/seq_detect_param.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_param
// Purpose  : Parametrised serial shift-compare pattern detector with
//            overlap mode, saturating match counter and sticky flag.
// Revision : 1.0 - initial release
// ============================================================================
module seq_detect_param #(
   parameter int          PAT_LEN = 4,
   parameter logic [31:0] PATTERN = 32'h0000_000B,
   parameter bit          OVERLAP = 1'b1,
   parameter int          CNT_W   = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr,
   input  logic                         sample_en,
   input  logic                         x,
   output logic                         match,
   output logic [CNT_W-1:0]             match_count,
   output logic                         seen,
   output logic [$clog2(PAT_LEN+1)-1:0] fill,
   output logic [PAT_LEN-1:0]           history
);

   localparam int                   c_FILL_W  = $clog2(PAT_LEN + 1);
   localparam logic [PAT_LEN-1:0]   c_PAT     = PATTERN[PAT_LEN-1:0];
   localparam logic [c_FILL_W-1:0]  c_FULL    = c_FILL_W'(PAT_LEN);
   localparam logic [CNT_W-1:0]     c_CNT_MAX = {CNT_W{1'b1}};

   logic                r_match;
   logic [CNT_W-1:0]    r_count;
   logic                r_seen;
   logic [c_FILL_W-1:0] r_fill;
   logic [PAT_LEN-1:0]  r_hist;

   logic [PAT_LEN-1:0]  w_h_next;
   logic [c_FILL_W-1:0] w_f_next;
   logic                w_hit;

   assign w_h_next = {r_hist[PAT_LEN-2:0], x};
   assign w_f_next = (r_fill == c_FULL) ? r_fill : r_fill + 1'b1;
   // Comparison is gated on a full window so an all-zero pattern cannot
   // match against the reset contents of the shift register.
   assign w_hit    = (w_f_next == c_FULL) && (w_h_next == c_PAT);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_match <= 1'b0;
         r_count <= '0;
         r_seen  <= 1'b0;
         r_fill  <= '0;
         r_hist  <= '0;
      end else begin
         r_match <= 1'b0;
         if (sample_en) begin
            r_match <= w_hit;
            if (w_hit) begin
               if (r_count != c_CNT_MAX) begin
                  r_count <= r_count + 1'b1;
               end
               r_seen <= 1'b1;
               if (OVERLAP) begin
                  r_hist <= w_h_next;
                  r_fill <= c_FULL;
               end else begin
                  r_hist <= '0;
                  r_fill <= '0;
               end
            end else begin
               r_hist <= w_h_next;
               r_fill <= w_f_next;
            end
         end
      end
   end

   assign match       = r_match;
   assign match_count = r_count;
   assign seen        = r_seen;
   assign fill        = r_fill;
   assign history     = r_hist;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detect_param
// Purpose  : Self-checking bench for seq_detect_param, four parameter sets
//            driven by one stimulus stream and checked against a window model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detect_param;

   logic clk = 1'b0;
   logic rst = 1'b1, clr = 1'b0, sample_en = 1'b0, x = 1'b0;

   always #5 clk = ~clk;

   logic       m0, m1, m2, m3;
   logic [7:0] c0, c1, c3;
   logic [1:0] c2;
   logic       s0, s1, s2, s3;
   logic [2:0] f0, f1, f2, f3;
   logic [3:0] h0, h1, h2;
   logic [5:0] h3;

   seq_detect_param #(.PAT_LEN(4), .PATTERN(32'hB), .OVERLAP(1'b1), .CNT_W(8)) u0 (
      .clk(clk), .rst(rst), .clr(clr), .sample_en(sample_en), .x(x),
      .match(m0), .match_count(c0), .seen(s0), .fill(f0), .history(h0));
   seq_detect_param #(.PAT_LEN(4), .PATTERN(32'hB), .OVERLAP(1'b0), .CNT_W(8)) u1 (
      .clk(clk), .rst(rst), .clr(clr), .sample_en(sample_en), .x(x),
      .match(m1), .match_count(c1), .seen(s1), .fill(f1), .history(h1));
   seq_detect_param #(.PAT_LEN(4), .PATTERN(32'hB), .OVERLAP(1'b1), .CNT_W(2)) u2 (
      .clk(clk), .rst(rst), .clr(clr), .sample_en(sample_en), .x(x),
      .match(m2), .match_count(c2), .seen(s2), .fill(f2), .history(h2));
   seq_detect_param #(.PAT_LEN(6), .PATTERN(32'h0), .OVERLAP(1'b1), .CNT_W(8)) u3 (
      .clk(clk), .rst(rst), .clr(clr), .sample_en(sample_en), .x(x),
      .match(m3), .match_count(c3), .seen(s3), .fill(f3), .history(h3));

   // Reference: window of the last L accepted bits (value + valid count).
   int mlen [4] = '{4, 4, 4, 6};
   int mpat [4] = '{11, 11, 11, 0};
   int movl [4] = '{1, 0, 1, 1};
   int mmax [4] = '{255, 255, 3, 255};
   int mh [4], mf [4], mc [4], ms [4], mm [4];

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_update(input logic r, input logic c, input logic e, input logic b);
      for (int k = 0; k < 4; k++) begin
         if (r || c) begin
            mh[k] = 0; mf[k] = 0; mc[k] = 0; ms[k] = 0; mm[k] = 0;
         end else if (e) begin
            mh[k] = ((mh[k] * 2) + int'(b)) % (1 << mlen[k]);
            if (mf[k] < mlen[k]) mf[k] = mf[k] + 1;
            mm[k] = (mf[k] == mlen[k] && mh[k] == mpat[k]) ? 1 : 0;
            if (mm[k] == 1) begin
               if (mc[k] < mmax[k]) mc[k] = mc[k] + 1;
               ms[k] = 1;
               if (movl[k] == 0) begin
                  mh[k] = 0; mf[k] = 0;
               end
            end
         end else begin
            mm[k] = 0;
         end
      end
   endtask

   task automatic check_inst(input int k, input logic mo, input logic [7:0] co,
                             input logic so, input logic [2:0] fo, input logic [5:0] ho);
      check($sformatf("u%0d.match", k), 64'(mo), 64'(mm[k]));
      check($sformatf("u%0d.count", k), 64'(co), 64'(mc[k]));
      check($sformatf("u%0d.seen", k),  64'(so), 64'(ms[k]));
      check($sformatf("u%0d.fill", k),  64'(fo), 64'(mf[k]));
      check($sformatf("u%0d.hist", k),  64'(ho), 64'(mh[k]));
   endtask

   task automatic step(input logic r, input logic c, input logic e, input logic b);
      @(negedge clk);
      rst = r; clr = c; sample_en = e; x = b;
      @(posedge clk);
      model_update(r, c, e, b);
      #1;
      check_inst(0, m0, c0, s0, f0, {2'b00, h0});
      check_inst(1, m1, c1, s1, f1, {2'b00, h1});
      check_inst(2, m2, {6'd0, c2}, s2, f2, {2'b00, h2});
      check_inst(3, m3, c3, s3, f3, h3);
   endtask

   int s2b [7]  = '{1, 0, 1, 1, 0, 1, 1};
   int s5b [16] = '{1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1};
   int pulses;

   initial begin
      // Reset and idle
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      repeat (10) step(0, 0, 0, 0);
      check("idle.hist", 64'(h0), 64'd0);
      check("idle.fill", 64'(f0), 64'd0);

      // Overlap vs non-overlap on the same stream
      foreach (s2b[i]) step(0, 0, 1, s2b[i][0]);
      check("ovl.count", 64'(c0), 64'd2);
      check("ovl.hist",  64'(h0), 64'hB);
      check("ovl.fill",  64'(f0), 64'd4);
      check("novl.count", 64'(c1), 64'd1);
      check("novl.hist",  64'(h1), 64'h3);
      check("novl.fill",  64'(f1), 64'd3);

      // Gapped strobes, then clear colliding with a sample
      step(1, 0, 0, 0);
      foreach (s2b[i]) begin
         step(0, 0, 1, s2b[i][0]);
         repeat (5) step(0, 0, 0, 0);
      end
      check("gap.count", 64'(c0), 64'd2);
      step(0, 1, 1, 1);
      check("clr.count", 64'(c0), 64'd0);
      check("clr.seen",  64'(s0), 64'd0);
      check("clr.fill",  64'(f0), 64'd0);

      // Saturation of the 2-bit counter
      step(1, 0, 0, 0);
      pulses = 0;
      foreach (s5b[i]) begin
         step(0, 0, 1, s5b[i][0]);
         if (m2 === 1'b1) pulses++;
      end
      check("sat.count",  64'(c2), 64'd3);
      check("sat.pulses", 64'(pulses), 64'd5);

      // All-zero 6-bit pattern needs a full window
      step(1, 0, 0, 0);
      repeat (5) step(0, 0, 1, 0);
      check("zero.nomatch", 64'(m3), 64'd0);
      step(0, 0, 1, 0);
      check("zero.match", 64'(m3), 64'd1);
      check("zero.fill",  64'(f3), 64'd6);
      step(0, 0, 1, 0);
      step(1, 0, 1, 0);
      check("zero.rst.fill",  64'(f3), 64'd0);
      check("zero.rst.count", 64'(c3), 64'd0);

      // Randomised traffic, biased to 1s so the 1011 pattern appears often
      for (int n = 0; n < 3000; n++) begin
         step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 2) != 0)   ? 1'b1 : 1'b0,
              ($urandom_range(0, 9) < 6)    ? 1'b1 : 1'b0);
      end
      // Long zero run exercises the zero-pattern instance in steady state
      repeat (20) step(0, 0, 1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
Parametrised serial pattern detector. It is the next generation of the fixed "three consecutive 1s" detector used on the board and generalises pattern length and value, adds an overlap/non-overlap mode, a match counter and a sticky flag. Bits arrive on x and are accepted only on a one-cycle sample strobe, which is already debounced and pulse-shaped upstream by the button handler. Outputs drive the 7-segment display path and downstream control logic.

Parameters:
PAT_LEN, 4, pattern length in bits; legal range 2..32.
PATTERN, 4'b1011, target pattern; bit PAT_LEN-1 is the oldest bit received, bit 0 the newest.
OVERLAP, 1, 1 = overlapping matches allowed; 0 = history flushed after each match.
CNT_W, 8, width of the match counter.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
clr  input  1  synchronous clear of history, fill, counter and sticky flag.
sample_en  input  1  one-cycle strobe; x is accepted on any rising edge where this is high.
x  input  1  serial data bit.
match  output  1  one-cycle pulse; registered.
match_count  output  CNT_W  number of matches, saturating.
seen  output  1  sticky; set by the first match.
fill  output  $clog2(PAT_LEN+1)  number of valid history bits (0..PAT_LEN).
history  output  PAT_LEN  shift-register contents; newest bit is in bit 0.

Behaviour:
- Reset (rst=1 at an edge): history=0, fill=0, match=0, match_count=0, seen=0. rst has priority over every other input.
- clr=1 (with rst=0): same effect as reset. clr wins over a simultaneous sample_en, and that sample is discarded.
- Sample (sample_en=1, no rst/clr):
  - h_next = {history[PAT_LEN-2:0], x}
  - f_next = min(fill+1, PAT_LEN)
  - hit = (f_next == PAT_LEN) && (h_next == PATTERN)
- No sample (sample_en=0): history, fill, match_count and seen hold; match=0.
- Latency: match is high during the single cycle after the edge that accepted the completing bit. A strobe held high for N cycles counts as N samples, because debouncing is an upstream responsibility.
- On hit with OVERLAP=1: history <= h_next; fill <= PAT_LEN.
- On hit with OVERLAP=0: history <= 0; fill <= 0, so the next match needs PAT_LEN fresh bits.
- On a miss: history <= h_next; fill <= f_next.
- match_count increments on each hit and saturates at 2^CNT_W-1; it never wraps.
- seen is set on a hit and cleared only by rst or clr.
- Detection is pure shift-compare, not a prefix-tracking FSM, so no partial-match fallback logic is needed.
- Bits of PATTERN above PAT_LEN-1 are ignored.
- Match checking is suppressed while fill < PAT_LEN, so a PATTERN of all zeros does not match right after reset.

Test Plan:
1. Reset and idle: assert rst for 2 cycles, then sample_en=0 for 10 cycles -> all outputs 0; history=4'b0000, fill=0.
2. Overlap detection (PATTERN=1011, OVERLAP=1): strobe bits 1,0,1,1,0,1,1 -> one match pulse after the 4th bit and one after the 7th; match_count=2, seen=1, fill=4, history=4'b1011.
3. Non-overlap (OVERLAP=0): same stream as scenario 2 -> single match after the 4th bit; fill goes to 0 and ends at 3; match_count=1; history=4'b0011.
4. Gaps and clear collision: insert 5 idle cycles between every strobe of scenario 2 -> identical match/count results. Then assert clr and sample_en in the same cycle -> count=0, seen=0, fill=0; the sampled bit is dropped.
5. Saturation (CNT_W=2): feed 5 overlapping matches (1,0,1,1,0,1,1,0,1,1,0,1,1,0,1,1) -> match_count reads 1,2,3,3,3; match still pulses 5 times.
6. Zero pattern / width (PAT_LEN=6, PATTERN=0): release reset, then 5 strobes of x=0 -> no match. Sixth strobe of x=0 -> match=1, fill=6. rst mid-stream -> everything is 0 on the next cycle.
